// File: rtl/vpu_pkg.sv
// vpu_pkg: VPU command encoding and the arbiter FSM state encoding.
package vpu_pkg;

    // Opcode that the vector unit accepts; anything else is rejected up front.
    localparam logic [7:0] VPU_OPCODE = 8'h02;

    // Vector sub-operations carried in the subop field.
    localparam logic [7:0] VOP_VADD = 8'h00;
    localparam logic [7:0] VOP_VSUB = 8'h01;
    localparam logic [7:0] VOP_VMUL = 8'h02;
    localparam logic [7:0] VOP_VMAC = 8'h03;

    // Command field bit positions.
    localparam int OPC_HI   = 127;
    localparam int OPC_LO   = 120;
    localparam int SUBOP_HI = 119;
    localparam int SUBOP_LO = 112;
    localparam int VD_HI    = 111;
    localparam int VD_LO    = 107;
    localparam int VS1_HI   = 106;
    localparam int VS1_LO   = 102;
    localparam int VS2_HI   = 101;
    localparam int VS2_LO   = 97;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } vpu_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; rr_ptr_i has the highest priority.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic               grant_valid_o,
    output logic [IDX_W-1:0]   grant_idx_o
);
    logic [IDX_W-1:0] cand;

    // Scan requesters starting at rr_ptr_i, wrapping at NUM_REQ; first valid one wins.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned and no latch is inferred.
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        cand          = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Modular add in IDX_W bits; the true result is always below NUM_REQ.
            if (int'(rr_ptr_i) + i >= NUM_REQ) begin
                cand = rr_ptr_i + IDX_W'(i) - IDX_W'(NUM_REQ);
            end else begin
                cand = rr_ptr_i + IDX_W'(i);
            end
            if (!grant_valid_o && req_valid_i[cand]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/vpu_cmd_arbiter.sv
// vpu_cmd_arbiter: forwards one command at a time from NUM_REQ requesters to the
// vector unit, with round-robin fairness, opcode rejection and a done timeout.
module vpu_cmd_arbiter
    import vpu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CMD_W   = 128,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ*CMD_W-1:0]   req_cmd,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         req_done,
    output logic [NUM_REQ-1:0]         req_err,
    output logic [CMD_W-1:0]           vpu_cmd,
    output logic                       vpu_cmd_valid,
    input  logic                       vpu_cmd_ready,
    input  logic                       vpu_cmd_done,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    vpu_state_e       state_q, state_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NUM_REQ-1:0][CMD_W-1:0] cmd_vec;
    logic                          arb_valid;
    logic [IDX_W-1:0]              arb_idx;
    logic [CMD_W-1:0]              pick_cmd;
    logic                          pick_ok;
    logic                          done_hit;
    logic                          tmo_hit;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_valid_i   (req_valid),
        .rr_ptr_i      (rr_ptr_q),
        .grant_valid_o (arb_valid),
        .grant_idx_o   (arb_idx)
    );

    assign cmd_vec  = req_cmd;
    assign pick_cmd = cmd_vec[arb_idx];
    assign pick_ok  = (pick_cmd[OPC_HI:OPC_LO] == VPU_OPCODE);
    // Done beats the timeout when both land in the same cycle.
    assign done_hit = (state_q == ST_WAIT_DONE) && vpu_cmd_done;
    assign tmo_hit  = (state_q == ST_WAIT_DONE) && !vpu_cmd_done && (cnt_q == CNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:      if (arb_valid && pick_ok) state_d = ST_ISSUE;
            ST_ISSUE:     if (vpu_cmd_ready) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (done_hit || tmo_hit) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: latched command/owner, round-robin pointer, timeout counter.
    always_comb begin
        cmd_d    = cmd_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    cmd_d   = pick_cmd;
                    grant_d = arb_idx;
                    if (!pick_ok) rr_ptr_d = wrap_inc(arb_idx);
                end
            end
            ST_ISSUE: begin
                if (vpu_cmd_ready) cnt_d = '0;
            end
            ST_WAIT_DONE: begin
                if (done_hit || tmo_hit) rr_ptr_d = wrap_inc(grant_q);
                else                     cnt_d    = cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the command register is reset because it drives vpu_cmd directly, which must read 0 in reset.
            cmd_q    <= '0;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            cmd_q    <= cmd_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs; the per-requester pulses are combinational and forced low while rst is high.
    always_comb begin
        req_ready     = '0;
        req_done      = '0;
        req_err       = '0;
        vpu_cmd       = cmd_q;
        vpu_cmd_valid = (state_q == ST_ISSUE);
        busy          = (state_q != ST_IDLE);
        grant_id      = grant_q;
        if (!rst) begin
            if (state_q == ST_IDLE && arb_valid) begin
                if (pick_ok) req_ready[arb_idx] = 1'b1;
                else         req_err[arb_idx]   = 1'b1;
            end
            if (done_hit) req_done[grant_q] = 1'b1;
            if (tmo_hit)  req_err[grant_q]  = 1'b1;
        end
    end

endmodule

// File: tb/tb_vpu_cmd_arbiter.sv
// tb_vpu_cmd_arbiter: directed and randomized transactions checked against a
// transaction-level round-robin model.
module tb_vpu_cmd_arbiter;
    import vpu_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int CMD_W   = 128;
    localparam int TIMEOUT = 16;

    logic                          clk;
    logic                          rst;
    logic [NUM_REQ-1:0][CMD_W-1:0] cmd_arr;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_done;
    logic [NUM_REQ-1:0]            req_err;
    logic [CMD_W-1:0]              vpu_cmd;
    logic                          vpu_cmd_valid;
    logic                          vpu_cmd_ready;
    logic                          vpu_cmd_done;
    logic                          busy;
    logic [IDX_W-1:0]              grant_id;

    int n_checks = 0;
    int n_fail   = 0;
    int m_ptr        = 0;   // requester with top priority at the next arbitration
    int m_last_owner = 0;   // last requester picked, shown on grant_id in IDLE

    vpu_cmd_arbiter #(
        .NUM_REQ (NUM_REQ),
        .CMD_W   (CMD_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_cmd       (cmd_arr),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_done      (req_done),
        .req_err       (req_err),
        .vpu_cmd       (vpu_cmd),
        .vpu_cmd_valid (vpu_cmd_valid),
        .vpu_cmd_ready (vpu_cmd_ready),
        .vpu_cmd_done  (vpu_cmd_done),
        .busy          (busy),
        .grant_id      (grant_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [CMD_W-1:0] obs, input logic [CMD_W-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CMD_W-1:0] pulses(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] d,
                                                input logic [NUM_REQ-1:0] e);
        return CMD_W'({r, d, e});
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [7:0] rand_bad_op();
        logic [7:0] op;
        op = 8'($urandom_range(0, 255));
        if (op == VPU_OPCODE) op = 8'h05;
        return op;
    endfunction

    function automatic logic [7:0] rand_any_op();
        return rbit() ? VPU_OPCODE : rand_bad_op();
    endfunction

    function automatic logic [7:0] rand_subop();
        logic [7:0] s;
        case ($urandom_range(0, 3))
            0:       s = VOP_VADD;
            1:       s = VOP_VSUB;
            2:       s = VOP_VMUL;
            default: s = VOP_VMAC;
        endcase
        return s;
    endfunction

    function automatic logic [CMD_W-1:0] make_cmd(input logic [7:0] op, input logic [7:0] subop);
        logic [CMD_W-1:0] c;
        c = {$urandom(), $urandom(), $urandom(), $urandom()};
        c[OPC_HI:OPC_LO]     = op;
        c[SUBOP_HI:SUBOP_LO] = subop;
        c[VD_HI:VD_LO]       = 5'($urandom_range(0, 31));
        c[VS1_HI:VS1_LO]     = 5'($urandom_range(0, 31));
        c[VS2_HI:VS2_LO]     = 5'($urandom_range(0, 31));
        return c;
    endfunction

    // Round-robin rule: first valid requester at or after ptr, wrapping.
    function automatic int rr_pick(input logic [NUM_REQ-1:0] mask, input int ptr);
        for (int i = 0; i < NUM_REQ; i++) begin
            int j;
            j = (ptr + i) % NUM_REQ;
            if (mask[IDX_W'(j)]) return j;
        end
        return -1;
    endfunction

    // Inputs that must have no effect outside IDLE.
    task automatic scramble();
        req_valid     = NUM_REQ'($urandom_range(0, 15));
        vpu_cmd_ready = rbit();
        for (int r = 0; r < NUM_REQ; r++) cmd_arr[IDX_W'(r)] = make_cmd(rand_any_op(), rand_subop());
    endtask

    task automatic idle_cycle();
        req_valid     = '0;
        vpu_cmd_ready = rbit();
        vpu_cmd_done  = rbit();
        #1;
        check("idle_pulses", pulses(req_ready, req_done, req_err), '0);
        check("idle_busy", CMD_W'(busy), '0);
        check("idle_vvalid", CMD_W'(vpu_cmd_valid), '0);
        check("idle_gid", CMD_W'(grant_id), CMD_W'(m_last_owner));
        @(negedge clk);
    endtask

    // One arbitration: grant cycle, then (valid opcode) `stall` refused issue cycles,
    // then WAIT_DONE until done at wait cycle done_dly, timeout, or reset at abort_k.
    task automatic txn(input logic [NUM_REQ-1:0] mask, input logic [7:0] win_op, input int stall,
                       input int done_dly, input int abort_k);
        logic [CMD_W-1:0]   win_cmd;
        logic [NUM_REQ-1:0] one;
        logic [NUM_REQ-1:0] zero;
        logic               bad;
        int                 w;
        w    = rr_pick(mask, m_ptr);
        bad  = (win_op != VPU_OPCODE);
        zero = '0;
        one  = '0;
        one[IDX_W'(w)] = 1'b1;
        for (int r = 0; r < NUM_REQ; r++)
            cmd_arr[IDX_W'(r)] = make_cmd((r == w) ? win_op : rand_any_op(), rand_subop());
        win_cmd       = cmd_arr[IDX_W'(w)];
        req_valid     = mask;
        vpu_cmd_ready = rbit();
        vpu_cmd_done  = rbit();
        #1;
        check("grant_pulses", pulses(req_ready, req_done, req_err), bad ? pulses(zero, zero, one) : pulses(one, zero, zero));
        check("grant_busy", CMD_W'(busy), '0);
        check("grant_vvalid", CMD_W'(vpu_cmd_valid), '0);
        check("grant_gid", CMD_W'(grant_id), CMD_W'(m_last_owner));
        @(negedge clk);
        m_last_owner = w;
        if (bad) begin
            m_ptr = (w + 1) % NUM_REQ;
            return;
        end
        for (int s = 0; s <= stall; s++) begin
            scramble();
            vpu_cmd_ready = (s == stall);
            vpu_cmd_done  = rbit();
            #1;
            check("issue_vvalid", CMD_W'(vpu_cmd_valid), CMD_W'(1));
            check("issue_cmd", vpu_cmd, win_cmd);
            check("issue_busy", CMD_W'(busy), CMD_W'(1));
            check("issue_gid", CMD_W'(grant_id), CMD_W'(w));
            check("issue_pulses", pulses(req_ready, req_done, req_err), '0);
            @(negedge clk);
        end
        for (int k = 0; k < TIMEOUT; k++) begin
            scramble();
            if (k == abort_k) begin
                vpu_cmd_done = 1'b1;
                rst          = 1'b1;
                #1;
                check("abort_pulses", pulses(req_ready, req_done, req_err), '0);
                check("abort_busy", CMD_W'(busy), '0);
                check("abort_vvalid", CMD_W'(vpu_cmd_valid), '0);
                check("abort_cmd", vpu_cmd, '0);
                check("abort_gid", CMD_W'(grant_id), '0);
                @(negedge clk);
                #1;
                check("abort_hold_pulses", pulses(req_ready, req_done, req_err), '0);
                rst          = 1'b0;
                req_valid    = '0;
                vpu_cmd_done = 1'b0;
                m_ptr        = 0;
                m_last_owner = 0;
                @(negedge clk);
                return;
            end
            vpu_cmd_done = (k == done_dly);
            #1;
            if (k == done_dly)          check("wait_pulses", pulses(req_ready, req_done, req_err), pulses(zero, one, zero));
            else if (k == TIMEOUT - 1)  check("wait_pulses", pulses(req_ready, req_done, req_err), pulses(zero, zero, one));
            else                        check("wait_pulses", pulses(req_ready, req_done, req_err), '0);
            check("wait_busy", CMD_W'(busy), CMD_W'(1));
            check("wait_vvalid", CMD_W'(vpu_cmd_valid), '0);
            check("wait_gid", CMD_W'(grant_id), CMD_W'(w));
            @(negedge clk);
            if (k == done_dly || k == TIMEOUT - 1) break;
        end
        m_ptr = (w + 1) % NUM_REQ;
    endtask

    initial begin
        // Reset with every requester presenting a valid command.
        rst           = 1'b1;
        req_valid     = '1;
        vpu_cmd_ready = 1'b1;
        vpu_cmd_done  = 1'b1;
        for (int r = 0; r < NUM_REQ; r++) cmd_arr[IDX_W'(r)] = make_cmd(VPU_OPCODE, VOP_VADD);
        @(negedge clk);
        #1;
        check("rst_pulses", pulses(req_ready, req_done, req_err), '0);
        check("rst_cmd", vpu_cmd, '0);
        check("rst_vvalid", CMD_W'(vpu_cmd_valid), '0);
        check("rst_busy", CMD_W'(busy), '0);
        check("rst_gid", CMD_W'(grant_id), '0);
        rst           = 1'b0;
        req_valid     = '0;
        vpu_cmd_ready = 1'b0;
        vpu_cmd_done  = 1'b0;
        @(negedge clk);

        // All requesters held valid: grants rotate 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            txn('1, VPU_OPCODE, 0, 2, -1);
            #1;
            check("rr_order", CMD_W'(grant_id), CMD_W'(i % NUM_REQ));
        end

        // Single requester, immediate transfer, done later; then back to idle.
        txn(4'b0001, VPU_OPCODE, 0, 3, -1);
        idle_cycle();

        // Vector unit stalls three cycles before accepting.
        txn(4'b0010, VPU_OPCODE, 3, 1, -1);

        // Bad opcode from requester 2, then requester 3 is next in line.
        txn(4'b0100, 8'h05, 0, 0, -1);
        txn(4'b1111, VPU_OPCODE, 0, 0, -1);
        #1;
        check("after_err_gid", CMD_W'(grant_id), CMD_W'(3));

        // Done never arrives: timeout error, then idle.
        txn(4'b0001, VPU_OPCODE, 1, -1, -1);
        idle_cycle();

        // Done on the timeout cycle: done wins.
        txn(4'b1000, VPU_OPCODE, 0, TIMEOUT - 1, -1);

        // Reset while waiting for done; next grant restarts at requester 0.
        txn(4'b0010, VPU_OPCODE, 0, -1, 4);
        txn(4'b1111, VPU_OPCODE, 0, 0, -1);
        #1;
        check("post_rst_gid", CMD_W'(grant_id), '0);

        // Randomized transactions.
        for (int n = 0; n < 40; n++) begin
            logic [NUM_REQ-1:0] mask;
            logic [7:0]         op;
            mask = NUM_REQ'($urandom_range(1, 15));
            op   = ($urandom_range(0, 3) == 0) ? rand_bad_op() : VPU_OPCODE;
            txn(mask, op, $urandom_range(0, 3), $urandom_range(0, TIMEOUT + 2), -1);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
